// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default data-path width and the
// 3-bit operation codes carried on alucontrol.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_NOR  = 3'b110,
        OP_SLTU = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Shared adder/subtractor for the ALU.
//   a_i, b_i    : operands (WIDTH bits)
//   sub_i       : 0 = a + b, 1 = a + ~b + 1
//   sum_o       : sum modulo 2^WIDTH
//   carry_o     : carry out of the top bit (for subtract, 1 = no borrow)
//   overflow_o  : signed overflow of the operation performed
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;

    // Subtraction folds into the same adder: invert b and inject the +1
    // through the carry-in.
    assign b_eff   = b_i ^ {WIDTH{sub_i}};
    assign sum_ext = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_i};

    assign sum_o   = sum_ext[WIDTH-1:0];
    assign carry_o = sum_ext[WIDTH];

    // Overflow when the effective operands share a sign and the sum does not.
    // With b inverted this is the "a and b differ in sign" rule for subtract.
    assign overflow_o = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                        (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule : alu_addsub

// File: rtl/alu.sv
// Registered 8-operation ALU.
//   clk        : rising-edge clock for the output register
//   reset      : asynchronous active-high reset, clears all outputs
//   a, b       : operands (WIDTH bits)
//   alucontrol : operation select (see alu_pkg::alu_op_e)
//   result     : registered result
//   zero       : registered "result is all zeros" flag
//   carry      : registered carry-out for ADD/SUB, 0 otherwise
//   overflow   : registered signed overflow for ADD/SUB, 0 otherwise
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic             sum_carry;
    logic             sum_ovf;
    logic             sub_sel;
    logic             lt_signed;
    logic             lt_unsigned;

    logic [WIDTH-1:0] result_d, result_q;
    logic             zero_d,   zero_q;
    logic             carry_d,  carry_q;
    logic             ovf_d,    ovf_q;

    // Everything except ADD runs the adder in subtract mode so SLT/SLTU
    // can reuse the a - b computation.
    assign sub_sel = (alucontrol != OP_ADD);

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a_i        (a),
        .b_i        (b),
        .sub_i      (sub_sel),
        .sum_o      (sum),
        .carry_o    (sum_carry),
        .overflow_o (sum_ovf)
    );

    // Signed compare corrects the difference sign by the overflow so it
    // stays right across the sign boundary; unsigned less-than is a borrow.
    assign lt_signed   = sum[WIDTH-1] ^ sum_ovf;
    assign lt_unsigned = ~sum_carry;

    always_comb begin
        result_d = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        case (alu_op_e'(alucontrol))
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_ADD,
            OP_SUB: begin
                result_d = sum;
                carry_d  = sum_carry;
                ovf_d    = sum_ovf;
            end
            OP_XOR:  result_d = a ^ b;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_NOR:  result_d = ~(a | b);
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
            default: result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    // zero clears to 0 under reset even though result is 0 there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;

endmodule : alu

// File: tb/tb_alu.sv
module tb_alu;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        string        name;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alucontrol;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .alucontrol (alucontrol),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation between edges, then sample just after the next edge.
    task automatic step(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        alucontrol = op;
        a          = av;
        b          = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (result !== '0 || zero !== 1'b0 || carry !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset_initial: got res=%h z=%b c=%b v=%b want res=0 z=0 c=0 v=0",
                     result, zero, carry, overflow);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result !== '0 || zero !== 1'b0)
            $display("FAIL reset_held_edges: got res=%h z=%b want res=0 z=0", result, zero);
        if (result !== '0 || zero !== 1'b0) failures++;
        if (!(result === '0 && zero === 1'b0 && carry === 1'b0 && overflow === 1'b0)) ;
        @(negedge clk);
        alucontrol = OP_OR;
        a          = 32'h11F1_1000;
        b          = 32'h0111_0D00;
        reset      = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'h11F1_1D00 || zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_first_edge: got res=%h z=%b want res=11f11d00 z=0",
                     result, zero);
        end
    endtask

    task automatic test_addsub();
        vec_t v[5];
        v[0] = '{OP_ADD, 32'h1000_0001, 32'hFFFF_FFFF, 32'h1000_0000, 1'b0, 1'b1, 1'b0, "add_carry"};
        v[1] = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, "add_overflow"};
        v[2] = '{OP_SUB, 32'h0000_0010, 32'h0000_0011, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_borrow"};
        v[3] = '{OP_SUB, 32'h1111_1111, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b1, 1'b0, "sub_equal"};
        v[4] = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, "sub_overflow"};
        for (int i = 0; i < 5; i++) begin
            step(v[i].op, v[i].av, v[i].bv);
            checks++;
            if (result !== v[i].res || zero !== v[i].z || carry !== v[i].c || overflow !== v[i].v) begin
                failures++;
                $display("FAIL %s: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                         v[i].name, result, zero, carry, overflow, v[i].res, v[i].z, v[i].c, v[i].v);
            end
        end
    endtask

    task automatic test_compare();
        vec_t v[6];
        v[0] = '{OP_SLT,  32'h0000_000F, 32'h0000_000A, 32'h0, 1'b1, 1'b0, 1'b0, "slt_f_a"};
        v[1] = '{OP_SLT,  32'h0000_000A, 32'h0000_000F, 32'h1, 1'b0, 1'b0, 1'b0, "slt_a_f"};
        v[2] = '{OP_SLT,  32'h0000_000A, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, "slt_a_neg1"};
        v[3] = '{OP_SLTU, 32'h0000_000A, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, "sltu_a_max"};
        v[4] = '{OP_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, "slt_min_max"};
        v[5] = '{OP_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, "sltu_min_max"};
        for (int i = 0; i < 6; i++) begin
            step(v[i].op, v[i].av, v[i].bv);
            checks++;
            if (result !== v[i].res || zero !== v[i].z || carry !== v[i].c || overflow !== v[i].v) begin
                failures++;
                $display("FAIL %s: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                         v[i].name, result, zero, carry, overflow, v[i].res, v[i].z, v[i].c, v[i].v);
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[5];
        v[0] = '{OP_ADD, 32'h1000_0001, 32'hFFFF_FFFF, 32'h1000_0000, 1'b0, 1'b1, 1'b0, "pre_carry"};
        v[1] = '{OP_AND, 32'h1000_0001, 32'hFFFF_FFFF, 32'h1000_0001, 1'b0, 1'b0, 1'b0, "and"};
        v[2] = '{OP_OR,  32'h11F1_1000, 32'h0111_0D00, 32'h11F1_1D00, 1'b0, 1'b0, 1'b0, "or"};
        v[3] = '{OP_XOR, 32'h1111_1111, 32'h1111_1111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "xor_zero"};
        v[4] = '{OP_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "nor"};
        for (int i = 0; i < 5; i++) begin
            step(v[i].op, v[i].av, v[i].bv);
            checks++;
            if (result !== v[i].res || zero !== v[i].z || carry !== v[i].c || overflow !== v[i].v) begin
                failures++;
                $display("FAIL %s: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                         v[i].name, result, zero, carry, overflow, v[i].res, v[i].z, v[i].c, v[i].v);
            end
        end
    endtask

    task automatic test_back_to_back();
        step(OP_ADD, 32'h0000_0003, 32'h0000_0004);
        checks++;
        if (result !== 32'h0000_0007) begin
            failures++;
            $display("FAIL b2b_first: got res=%h want res=00000007", result);
        end
        @(negedge clk);
        alucontrol = OP_XOR;
        a          = 32'hA5A5_A5A5;
        b          = 32'h0F0F_0F0F;
        #1;
        checks++;
        if (result !== 32'h0000_0007) begin
            failures++;
            $display("FAIL b2b_latency_hold: got res=%h want res=00000007", result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'hAAAA_AAAA || zero !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: got res=%h z=%b want res=aaaaaaaa z=0", result, zero);
        end
        step(OP_SUB, 32'h0000_0005, 32'h0000_0005);
        checks++;
        if (result !== 32'h0 || zero !== 1'b1 || carry !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL b2b_third: got res=%h z=%b c=%b v=%b want res=0 z=1 c=1 v=0",
                     result, zero, carry, overflow);
        end
    endtask

    task automatic test_reset_mid();
        step(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        checks++;
        if (result !== 32'h8000_0000 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_setup: got res=%h v=%b want res=80000000 v=1", result, overflow);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (result !== '0 || zero !== 1'b0 || carry !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: got res=%h z=%b c=%b v=%b want res=0 z=0 c=0 v=0",
                     result, zero, carry, overflow);
        end
        @(negedge clk);
        alucontrol = OP_AND;
        a          = 32'hFFFF_FFFF;
        b          = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        checks++;
        if (result !== '0 || zero !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_discard: got res=%h z=%b want res=0 z=0", result, zero);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (result !== 32'hFFFF_FFFF || zero !== 1'b0 || carry !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_release: got res=%h z=%b c=%b want res=ffffffff z=0 c=0",
                     result, zero, carry);
        end
    endtask

    initial begin
        reset      = 1'b1;
        a          = '0;
        b          = '0;
        alucontrol = OP_AND;
        test_reset();
        test_addsub();
        test_compare();
        test_logic();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu
